// File: rtl/alu_result_stage.sv
// ALU result/writeback stage: result FIFO, accumulator, SVNZ status, branch condition.
// Optional: define ALU_STICKY_V_EN to make the overflow flag sticky until reset.
module alu_result_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int DW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             s,
  input  logic             v,
  input  logic             n,
  input  logic             z,
  input  logic [DW-1:0]    dest,
  input  logic             flag_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [DW-1:0]    out_dest,
  output logic [WIDTH-1:0] acc,
  output logic [3:0]       status,
  input  logic [2:0]       cond,
  output logic             cond_true
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } occ_t;

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [DW-1:0]    mem_dest [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  occ_t             occ;
  logic             push;
  logic             pop;
  logic             v_next;

  always_comb begin
    occ = PARTIAL;
    unique case (1'b1)
      (count == '0):           occ = EMPTY;
      (count == CW'(DEPTH)):   occ = FULL;
      default:                 occ = PARTIAL;
    endcase
  end

  assign in_ready  = (occ != FULL);
  assign out_valid = (occ != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_dest  = out_valid ? mem_dest[rd_ptr] : '0;

`ifdef ALU_STICKY_V_EN
  assign v_next = status[2] | v;
`else
  assign v_next = v;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_dest[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      acc    <= '0;
      status <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= sum;
        mem_dest[wr_ptr] <= dest;
        wr_ptr <= wr_ptr + AW'(1);
        acc    <= sum;
        if (flag_we)
          status <= {s, v_next, n, z};
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // status is {S,V,N,Z}
  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      3'd0: cond_true = 1'b1;
      3'd1: cond_true = status[0];
      3'd2: cond_true = ~status[0];
      3'd3: cond_true = status[1];
      3'd4: cond_true = ~status[1];
      3'd5: cond_true = status[2];
      3'd6: cond_true = ~status[2];
      3'd7: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed scenarios then random traffic.
// Expected results come from a queue-based reference model of the stage.
module tb_alu_result_stage;

  logic       clk = 0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] sum;
  logic       s, v, n, z;
  logic [2:0] dest;
  logic       flag_we;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_dest;
  logic [7:0] acc;
  logic [3:0] status;
  logic [2:0] cond;
  logic       cond_true;

  int compared   = 0;
  int mismatched = 0;
  bit rnd_rdy    = 0;

  logic [10:0] q[$];
  logic [7:0]  m_acc;
  bit          m_s, m_v, m_n, m_z;

  alu_result_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .s(s), .v(v), .n(n), .z(z),
    .dest(dest), .flag_we(flag_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_dest(out_dest),
    .acc(acc), .status(status),
    .cond(cond), .cond_true(cond_true)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Branch condition expressed on the named flags.
  function automatic bit ref_cond(bit fs, bit fv, bit fn, bit fz, logic [2:0] c);
    case (c)
      3'd0: return 1;
      3'd1: return fz;
      3'd2: return !fz;
      3'd3: return fn;
      3'd4: return !fn;
      3'd5: return fv;
      3'd6: return !fv;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    q.delete();
    m_acc = 0;
    {m_s, m_v, m_n, m_z} = 4'b0000;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive(logic [7:0] d, logic [2:0] dst, logic [3:0] f, logic we);
    int w;
    in_valid = 1; sum = d; dest = dst;
    {s, v, n, z} = f; flag_we = we;
    w = 0;
    @(negedge clk); #2;
    while (!in_ready && w < 50) begin
      @(negedge clk); #2;
      w++;
    end
    if (!in_ready) begin
      chk("drive_timeout", 0, 1);
    end else begin
      q.push_back({dst, d});
      m_acc = d;
      if (we) begin
        m_s = f[3];
`ifdef ALU_STICKY_V_EN
        m_v = m_v | f[2];
`else
        m_v = f[2];
`endif
        m_n = f[1];
        m_z = f[0];
      end
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic idle(int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("acc", acc, m_acc);
        chk("status", status, {m_s, m_v, m_n, m_z});
        chk("cond_true", cond_true, ref_cond(m_s, m_v, m_n, m_z, cond));
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() != 2);
        if (out_valid && q.size() != 0) begin
          e = q[0];
          chk("out_data", out_data, e[7:0]);
          chk("out_dest", out_dest, e[10:8]);
          if (out_ready) void'(q.pop_front());
        end else if (!out_valid) begin
          chk("empty_data", out_data, 0);
          chk("empty_dest", out_dest, 0);
        end
      end
    end
  end

  initial begin : rdy_gen
    forever begin
      @(posedge clk); #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : stim
    int w;
    reset = 1; in_valid = 0; sum = 0; dest = 0;
    {s, v, n, z} = 4'b0000; flag_we = 0;
    out_ready = 0; cond = 0;
    model_reset();
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_dest", out_dest, 0);
    chk("rst_cond_true", cond_true, 1);
    chk("rst_acc", acc, 0);
    chk("rst_status", status, 0);
    @(posedge clk); #1;
    reset = 0;

    // single push, consumed right away
    out_ready = 1;
    drive(8'h5A, 3'd3, 4'b0000, 0);
    chk("t2_valid", out_valid, 1);
    chk("t2_data", out_data, 8'h5A);
    chk("t2_dest", out_dest, 3);
    chk("t2_acc", acc, 8'h5A);
    idle(2);

    // fill, block, then drain in order
    out_ready = 0;
    drive(8'h01, 3'd1, 4'b0000, 0);
    drive(8'h02, 3'd2, 4'b0000, 0);
    fork
      drive(8'h03, 3'd4, 4'b0000, 0);
      begin
        repeat (2) @(negedge clk);
        #1 chk("t3_full_ready", in_ready, 0);
        chk("t3_held", out_data, 8'h01);
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    idle(4);

    // flag update vs. flag hold
    cond = 3'd1;
    drive(8'h00, 3'd0, 4'b0001, 1);
    drive(8'h80, 3'd5, 4'b0010, 0);
    chk("t4_cond", cond_true, 1);
    chk("t4_acc", acc, 8'h80);
    chk("t4_status", status, 4'b0001);
    idle(3);

    // back-to-back push+pop in PARTIAL, across pointer wrap
    for (int i = 0; i < 6; i++)
      drive(8'h10 + 8'(i), 3'(i), 4'b0000, 0);
    idle(3);

    // overflow flag: set then clear request
    cond = 3'd5;
    drive(8'h7F, 3'd6, 4'b0100, 1);
    drive(8'h11, 3'd7, 4'b0000, 1);
`ifdef ALU_STICKY_V_EN
    chk("t6_cond", cond_true, 1);
`else
    chk("t6_cond", cond_true, 0);
`endif
    idle(3);

    // reset with two entries queued
    out_ready = 0;
    drive(8'hA1, 3'd1, 4'b1111, 1);
    drive(8'hA2, 3'd2, 4'b1010, 1);
    #2 reset = 1;
    #1;
    chk("t1_out_valid", out_valid, 0);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_acc", acc, 0);
    chk("t1_status", status, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    idle(1);

    // random traffic
    rnd_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      cond = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0)
        idle(1);
      else
        drive(8'($urandom), 3'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    end

    rnd_rdy = 0;
    #1 out_ready = 1;
    w = 0;
    while (q.size() != 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    chk("drain_empty", q.size(), 0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
